// File: rtl/cc_speed_ticker.sv
// cc_speed_ticker: level-driven gravity tick generator.
// Owns the period counter and derives the tick period from the applied level.
// Supports pause, restart and a soft-drop (fast) cap on the period.
// The tick is active-low and lasts exactly one cycle.
module cc_speed_ticker #(
  parameter int DATAWIDTH   = 23,
  parameter int LEVELWIDTH  = 2,
  parameter int BASE_PERIOD = 8388607,
  parameter int STEP_PERIOD = 2097152,
  parameter int MIN_PERIOD  = 1048576,
  parameter int FAST_PERIOD = 524288
) (
  input  logic                  CC_SPEEDTICKER_CLOCK_50,
  input  logic                  CC_SPEEDTICKER_RESET_InHigh,
  input  logic                  CC_SPEEDTICKER_enable_InHigh,
  input  logic                  CC_SPEEDTICKER_restart_InHigh,
  input  logic                  CC_SPEEDTICKER_fast_InHigh,
  input  logic [LEVELWIDTH-1:0] CC_SPEEDTICKER_level_InBUS,
  output logic                  CC_SPEEDTICKER_T0_OutLow,
  output logic [LEVELWIDTH-1:0] CC_SPEEDTICKER_level_OutBUS,
  output logic [DATAWIDTH-1:0]  CC_SPEEDTICKER_count_OutBUS,
  output logic                  CC_SPEEDTICKER_running_OutHigh
);

  // Period arithmetic width: room for the level product plus a sign bit.
  localparam int PW = DATAWIDTH + LEVELWIDTH + 1;
  localparam longint PERIOD_LIMIT = longint'(1) << DATAWIDTH;

  localparam logic signed [PW-1:0] BASE_S = PW'(BASE_PERIOD);
  localparam logic signed [PW-1:0] STEP_S = PW'(STEP_PERIOD);
  localparam logic signed [PW-1:0] MIN_S  = PW'(MIN_PERIOD);
  localparam logic [DATAWIDTH-1:0] MIN_U  = DATAWIDTH'(MIN_PERIOD);
  localparam logic [DATAWIDTH-1:0] FAST_U = DATAWIDTH'(FAST_PERIOD);

  // Every period must be at least 2 cycles and fit in the counter.
  if (BASE_PERIOD < 2 || longint'(BASE_PERIOD) >= PERIOD_LIMIT ||
      MIN_PERIOD  < 2 || longint'(MIN_PERIOD)  >= PERIOD_LIMIT ||
      FAST_PERIOD < 2 || longint'(FAST_PERIOD) >= PERIOD_LIMIT ||
      STEP_PERIOD < 0 || longint'(STEP_PERIOD) >= PERIOD_LIMIT) begin : gBadPeriod
    $error("cc_speed_ticker: period parameters out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } tickerState_t;

  tickerState_t            state_p0, stateNext;
  logic [DATAWIDTH-1:0]    count_p0, countNext;
  logic [LEVELWIDTH-1:0]   level_p0, levelNext;
  logic                    t0_p0, t0Next;
  logic                    running_p0;

  logic signed [PW-1:0]    levelS;
  logic signed [PW-1:0]    rawPeriod;
  logic [DATAWIDTH-1:0]    levelPeriod;
  logic [DATAWIDTH-1:0]    activePeriod;
  logic                    terminal;

  // Clamp the level-derived period to the floor; negative results land here too.
  function automatic logic [DATAWIDTH-1:0] floorPeriod(input logic signed [PW-1:0] raw);
    if (raw < MIN_S) floorPeriod = MIN_U;
    else             floorPeriod = raw[DATAWIDTH-1:0];
  endfunction

  // Soft-drop caps the period but never lengthens an already short one.
  function automatic logic [DATAWIDTH-1:0] capPeriod(input logic [DATAWIDTH-1:0] p,
                                                     input logic fast);
    if (fast && (p > FAST_U)) capPeriod = FAST_U;
    else                      capPeriod = p;
  endfunction

  // Period derivation from the applied level (never the requested one).
  always_comb begin
    levelS       = $signed(PW'(level_p0));
    rawPeriod    = BASE_S - (levelS * STEP_S);
    levelPeriod  = floorPeriod(rawPeriod);
    activePeriod = capPeriod(levelPeriod, CC_SPEEDTICKER_fast_InHigh);
    // >= so that a freshly applied shorter cap fires on the next edge.
    terminal     = (count_p0 >= (activePeriod - DATAWIDTH'(1)));
  end

  // Next-state and next-output logic; restart outranks every state action.
  always_comb begin
    stateNext = state_p0;
    countNext = count_p0;
    levelNext = level_p0;
    t0Next    = 1'b1;
    if (CC_SPEEDTICKER_restart_InHigh) begin
      countNext = '0;
      levelNext = CC_SPEEDTICKER_level_InBUS;
      stateNext = CC_SPEEDTICKER_enable_InHigh ? RUN : IDLE;
    end else begin
      unique case (state_p0)
        IDLE: begin
          countNext = '0;
          levelNext = CC_SPEEDTICKER_level_InBUS;
          if (CC_SPEEDTICKER_enable_InHigh) stateNext = RUN;
        end
        RUN: begin
          if (!CC_SPEEDTICKER_enable_InHigh) begin
            stateNext = PAUSE;
          end else if (terminal) begin
            countNext = '0;
            t0Next    = 1'b0;
            levelNext = CC_SPEEDTICKER_level_InBUS;
          end else begin
            countNext = count_p0 + DATAWIDTH'(1);
          end
        end
        PAUSE: begin
          if (CC_SPEEDTICKER_enable_InHigh) stateNext = RUN;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CC_SPEEDTICKER_CLOCK_50) begin
    if (CC_SPEEDTICKER_RESET_InHigh) begin
      state_p0   <= IDLE;
      count_p0   <= '0;
      level_p0   <= '0;
      t0_p0      <= 1'b1;
      running_p0 <= 1'b0;
    end else begin
      state_p0   <= stateNext;
      count_p0   <= countNext;
      level_p0   <= levelNext;
      t0_p0      <= t0Next;
      running_p0 <= (stateNext == RUN);
    end
  end

  assign CC_SPEEDTICKER_T0_OutLow       = t0_p0;
  assign CC_SPEEDTICKER_level_OutBUS    = level_p0;
  assign CC_SPEEDTICKER_count_OutBUS    = count_p0;
  assign CC_SPEEDTICKER_running_OutHigh = running_p0;

endmodule

// File: doc/cc_speed_ticker.md
Name: cc_speed_ticker

Overview:
Parametrised gravity/speed tick generator for the game datapath. It replaces the external free-running counter plus fixed-threshold comparator pair.
- Owns the period counter.
- Derives the tick period arithmetically from the current level.
- Supports pause, restart and a fast (soft-drop) override.
- Emits a one-cycle active-low tick to the game FSM.

Parameters:
DATAWIDTH, 23, counter and period width.
LEVELWIDTH, 2, level bus width (2^LEVELWIDTH levels).
BASE_PERIOD, 8388607, period at level 0, in clock cycles.
STEP_PERIOD, 2097152, period reduction per level.
MIN_PERIOD, 1048576, floor for the level-derived period.
FAST_PERIOD, 524288, period cap while fast mode is asserted.

Ports:
CC_SPEEDTICKER_CLOCK_50  in  1  system clock; all logic on its rising edge.
CC_SPEEDTICKER_RESET_InHigh  in  1  synchronous, active-high reset.
CC_SPEEDTICKER_enable_InHigh  in  1  1 = run, 0 = pause.
CC_SPEEDTICKER_restart_InHigh  in  1  clear period and reload level (one-cycle strobe).
CC_SPEEDTICKER_fast_InHigh  in  1  soft-drop override.
CC_SPEEDTICKER_level_InBUS  in  LEVELWIDTH  requested level.
CC_SPEEDTICKER_T0_OutLow  out  1  tick; low for exactly one cycle per period.
CC_SPEEDTICKER_level_OutBUS  out  LEVELWIDTH  level currently applied.
CC_SPEEDTICKER_count_OutBUS  out  DATAWIDTH  current counter value.
CC_SPEEDTICKER_running_OutHigh  out  1  high when state is RUN.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: T0_OutLow = 1, count = 0, level_OutBUS = 0, running = 0, state = IDLE.
- Period arithmetic (combinational, from level_OutBUS, never from level_InBUS):
  - Plev = BASE_PERIOD − L*STEP_PERIOD, computed in DATAWIDTH+LEVELWIDTH+1 bits, signed-safe.
  - If the result is below MIN_PERIOD (including negative), Plev = MIN_PERIOD.
  - Pact = fast ? min(Plev, FAST_PERIOD) : Plev.
  - All periods ≥ 2 and < 2^DATAWIDTH; the implementation rejects violations at elaboration.
- States: IDLE, RUN, PAUSE.
  - IDLE: count = 0, T0 = 1, level_OutBUS follows level_InBUS every cycle. enable = 1 → RUN.
  - RUN, every edge:
    - If count ≥ Pact−1: count ← 0, T0 ← 0, level_OutBUS ← level_InBUS.
    - Else: count ← count+1, T0 ← 1.
    - enable = 0 → PAUSE (no count update on that edge, T0 ← 1).
  - PAUSE: count held, T0 = 1, level_OutBUS held. enable = 1 → RUN; counting resumes from the held value.
- Tick spacing in steady RUN is exactly Pact cycles.
- The first tick after entering RUN from count = 0 appears in the cycle after the Pact-th RUN edge.
- Level change mid-period takes effect only at the next period boundary. There is no partial-period shortening from a level change.
- Fast mode takes effect immediately, since the comparison is ≥.
  - If count ≥ FAST_PERIOD−1 when fast rises, the tick fires on the next edge.
  - Fast falling mid-period lets the count continue toward Plev.
- restart (priority below reset, above everything else):
  - count ← 0, T0 ← 1, level_OutBUS ← level_InBUS.
  - Next state is RUN if enable, else IDLE.
  - A restart coinciding with a terminal count suppresses that tick.
- Reset mid-period: all outputs return to reset values on that edge. No tick is emitted.
- running_OutHigh = (state == RUN), registered with the state.

Test Plan:
Bench parameters: DATAWIDTH 8, LEVELWIDTH 2, BASE 20, STEP 6, MIN 5, FAST 3. Expected Plev for L0..L3 = 20, 14, 8, 5 (L3 clamped from 2).
1. Reset, level 0, enable = 1 held → T0 low one cycle every 20 cycles; count ramps 0..19; running = 1; after reset, count = 0 and T0 = 1.
2. Level 0 running, set level_InBUS = 2 at count = 5 → current period still ends at 20; level_OutBUS becomes 2 with that tick; subsequent spacing is 8. Level 3 → spacing 5 (floor clamp).
3. Level 1, count = 10, assert fast → tick on next edge (10 ≥ 2), then spacing 3. Deassert fast at count = 1 → next tick 14 cycles after the previous one.
4. Level 0, drop enable at count = 7 for 30 cycles → count holds 7, no tick, running = 0. Re-enable → tick exactly 13 RUN edges later.
5. Pulse restart on the same edge where count = 19 with enable = 1 → no tick; count = 0; next tick 20 cycles later. Restart with enable = 0 → state IDLE and level_OutBUS tracks level_InBUS.
6. Assert reset mid-PAUSE with count = 12 → count = 0, T0 = 1, level_OutBUS = 0, running = 0, state IDLE.
